// File: rtl/plb_cache_arbiter.sv
// plb_cache_arbiter: shares the PLB cache memory port between the lookup
// stage (lkp_*) and the refill path (rfl_*), routing responses in order.
// Ports: clk_i/rst_ni (sync, active-low), flush_i, lkp_mem_* and rfl_mem_*
// slave ports, plb_cache_mem_* master port, outstanding_o, protocol_error_o.
// Optional: define MPT_PLB_ARB_RR_EN for round-robin arbitration
// (default build is fixed priority, refill over lookup).
module plb_cache_arbiter #(
  parameter int DATA_WIDTH      = 1,
  parameter int ADDR_WIDTH      = 64,
  parameter int BE_WIDTH        = (DATA_WIDTH + 7) / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           lkp_mem_req,
  output logic                           lkp_mem_gnt,
  output logic                           lkp_mem_valid,
  input  logic [ADDR_WIDTH-1:0]          lkp_mem_addr,
  input  logic                           lkp_mem_we,
  input  logic [BE_WIDTH-1:0]            lkp_mem_be,
  input  logic [DATA_WIDTH-1:0]          lkp_mem_wdata,
  output logic [DATA_WIDTH-1:0]          lkp_mem_rdata,
  output logic                           lkp_mem_error,
  input  logic                           rfl_mem_req,
  output logic                           rfl_mem_gnt,
  output logic                           rfl_mem_valid,
  input  logic [ADDR_WIDTH-1:0]          rfl_mem_addr,
  input  logic                           rfl_mem_we,
  input  logic [BE_WIDTH-1:0]            rfl_mem_be,
  input  logic [DATA_WIDTH-1:0]          rfl_mem_wdata,
  output logic [DATA_WIDTH-1:0]          rfl_mem_rdata,
  output logic                           rfl_mem_error,
  output logic                           plb_cache_mem_req,
  output logic [ADDR_WIDTH-1:0]          plb_cache_mem_addr,
  output logic [DATA_WIDTH-1:0]          plb_cache_mem_wdata,
  output logic                           plb_cache_mem_we,
  output logic [BE_WIDTH-1:0]            plb_cache_mem_be,
  input  logic                           plb_cache_mem_gnt,
  input  logic                           plb_cache_mem_valid,
  input  logic [DATA_WIDTH-1:0]          plb_cache_mem_rdata,
  input  logic                           plb_cache_mem_error,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                           protocol_error_o
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic ID_LKP = 1'b0;
  localparam logic ID_RFL = 1'b1;

  logic [PW:0]                r_wptr;
  logic [PW:0]                r_rptr;
  logic [MAX_OUTSTANDING-1:0] r_ids;
  logic                       r_lock;
  logic                       r_lock_sel;
  logic                       r_perr;
`ifdef MPT_PLB_ARB_RR_EN
  logic                       r_rr_last;
`endif

  logic w_empty;
  logic w_full;
  logic w_sel;
  logic w_sel_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_empty = (r_wptr == r_rptr);
  // Extra pointer bit distinguishes full from empty.
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

  // A locked selection wins over any new request until it is granted.
  always_comb begin
    w_sel = ID_LKP;
    if (r_lock)
      w_sel = r_lock_sel;
    else if (rfl_mem_req && lkp_mem_req)
`ifdef MPT_PLB_ARB_RR_EN
      w_sel = ~r_rr_last;
`else
      w_sel = ID_RFL;
`endif
    else if (rfl_mem_req)
      w_sel = ID_RFL;
  end

  assign w_sel_req = w_sel ? rfl_mem_req : lkp_mem_req;

  // Flush only holds back new arbitration; a locked request stays up.
  assign plb_cache_mem_req   = w_sel_req & ~w_full & (r_lock | ~flush_i);
  assign plb_cache_mem_addr  = w_sel ? rfl_mem_addr  : lkp_mem_addr;
  assign plb_cache_mem_wdata = w_sel ? rfl_mem_wdata : lkp_mem_wdata;
  assign plb_cache_mem_we    = w_sel ? rfl_mem_we    : lkp_mem_we;
  assign plb_cache_mem_be    = w_sel ? rfl_mem_be    : lkp_mem_be;

  assign w_push = plb_cache_mem_req & plb_cache_mem_gnt;
  assign lkp_mem_gnt = w_push & (w_sel == ID_LKP);
  assign rfl_mem_gnt = w_push & (w_sel == ID_RFL);

  // A response with nothing in flight is dropped, never popped.
  assign w_pop  = plb_cache_mem_valid & ~w_empty;
  assign w_head = r_ids[r_rptr[PW-1:0]];

  assign lkp_mem_valid = w_pop & (w_head == ID_LKP);
  assign rfl_mem_valid = w_pop & (w_head == ID_RFL);
  assign lkp_mem_rdata = lkp_mem_valid ? plb_cache_mem_rdata : '0;
  assign rfl_mem_rdata = rfl_mem_valid ? plb_cache_mem_rdata : '0;
  assign lkp_mem_error = lkp_mem_valid & plb_cache_mem_error;
  assign rfl_mem_error = rfl_mem_valid & plb_cache_mem_error;

  assign outstanding_o    = r_wptr - r_rptr;
  assign protocol_error_o = r_perr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ids      <= '0;
      r_lock     <= 1'b0;
      r_lock_sel <= ID_LKP;
      r_perr     <= 1'b0;
`ifdef MPT_PLB_ARB_RR_EN
      r_rr_last  <= ID_LKP;
`endif
    end else begin
      if (w_push) begin
        r_ids[r_wptr[PW-1:0]] <= w_sel;
        r_wptr <= r_wptr + (PW+1)'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + (PW+1)'(1);
      if (plb_cache_mem_valid && w_empty)
        r_perr <= 1'b1;
      if (w_push) begin
        r_lock <= 1'b0;
      end else if (plb_cache_mem_req) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end
`ifdef MPT_PLB_ARB_RR_EN
      if (w_push)
        r_rr_last <= w_sel;
`endif
    end
  end

endmodule

// File: tb/tb_plb_cache_arbiter.sv
// tb_plb_cache_arbiter: directed scenarios plus a randomized run checked
// against a queue-based model of the PLB cache arbiter.
module tb_plb_cache_arbiter;

  localparam int DW = 1;
  localparam int AW = 64;
  localparam int BW = 1;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic lkp_req, lkp_gnt, lkp_valid, lkp_we, lkp_error;
  logic [AW-1:0] lkp_addr;
  logic [BW-1:0] lkp_be;
  logic [DW-1:0] lkp_wdata, lkp_rdata;
  logic rfl_req, rfl_gnt, rfl_valid, rfl_we, rfl_error;
  logic [AW-1:0] rfl_addr;
  logic [BW-1:0] rfl_be;
  logic [DW-1:0] rfl_wdata, rfl_rdata;
  logic m_req, m_we, m_gnt, m_valid, m_error;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [BW-1:0] m_be;
  logic [2:0] outstanding;
  logic perr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  plb_cache_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .lkp_mem_req(lkp_req), .lkp_mem_gnt(lkp_gnt), .lkp_mem_valid(lkp_valid),
    .lkp_mem_addr(lkp_addr), .lkp_mem_we(lkp_we), .lkp_mem_be(lkp_be),
    .lkp_mem_wdata(lkp_wdata), .lkp_mem_rdata(lkp_rdata),
    .lkp_mem_error(lkp_error),
    .rfl_mem_req(rfl_req), .rfl_mem_gnt(rfl_gnt), .rfl_mem_valid(rfl_valid),
    .rfl_mem_addr(rfl_addr), .rfl_mem_we(rfl_we), .rfl_mem_be(rfl_be),
    .rfl_mem_wdata(rfl_wdata), .rfl_mem_rdata(rfl_rdata),
    .rfl_mem_error(rfl_error),
    .plb_cache_mem_req(m_req), .plb_cache_mem_addr(m_addr),
    .plb_cache_mem_wdata(m_wdata), .plb_cache_mem_we(m_we),
    .plb_cache_mem_be(m_be), .plb_cache_mem_gnt(m_gnt),
    .plb_cache_mem_valid(m_valid), .plb_cache_mem_rdata(m_rdata),
    .plb_cache_mem_error(m_error),
    .outstanding_o(outstanding), .protocol_error_o(perr)
  );

  task automatic zero_inputs();
    flush = 0; m_gnt = 0; m_valid = 0; m_rdata = '0; m_error = 0;
    lkp_req = 0; lkp_addr = '0; lkp_we = 0; lkp_be = '0; lkp_wdata = '0;
    rfl_req = 0; rfl_addr = '0; rfl_we = 0; rfl_be = '0; rfl_wdata = '0;
  endtask

  // Leaves the bench just after a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    zero_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    zero_inputs();
    m_valid = 1;
    @(posedge clk);
    @(negedge clk);
    m_valid = 0;
    #1;
    checks++;
    if (outstanding !== 3'd0 || perr !== 1'b0 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: outst=%0d perr=%0b req=%0b want 0 0 0",
               outstanding, perr, m_req);
    end
    checks++;
    if (lkp_valid !== 0 || rfl_valid !== 0 || lkp_gnt !== 0 ||
        rfl_gnt !== 0 || lkp_rdata !== 0 || rfl_error !== 0) begin
      errors++;
      $display("FAIL reset_outputs: lv=%0b rv=%0b lg=%0b rg=%0b want 0",
               lkp_valid, rfl_valid, lkp_gnt, rfl_gnt);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_lookup_single();
    do_reset();
    lkp_req = 1; lkp_addr = 64'h1000; m_gnt = 1;
    #1;
    checks++;
    if (m_req !== 1 || m_addr !== 64'h1000 || lkp_gnt !== 1 || rfl_gnt !== 0)
    begin
      errors++;
      $display("FAIL single_grant: req=%0b addr=%h lg=%0b rg=%0b want 1 1000 1 0",
               m_req, m_addr, lkp_gnt, rfl_gnt);
    end
    @(negedge clk);
    lkp_req = 0; m_gnt = 0;
    #1;
    checks++;
    if (outstanding !== 3'd1) begin
      errors++;
      $display("FAIL single_outst1: got %0d want 1", outstanding);
    end
    @(negedge clk);
    m_valid = 1; m_rdata = 1'b1;
    #1;
    checks++;
    if (lkp_valid !== 1 || lkp_rdata !== 1'b1 || rfl_valid !== 0) begin
      errors++;
      $display("FAIL single_resp: lv=%0b ld=%0b rv=%0b want 1 1 0",
               lkp_valid, lkp_rdata, rfl_valid);
    end
    @(negedge clk);
    m_valid = 0; m_rdata = 0;
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("FAIL single_outst0: got %0d want 0", outstanding);
    end
    @(negedge clk);
  endtask

  task automatic test_fill_full();
    bit q[$];
    bit exp_id;
    do_reset();
    lkp_req = 1; rfl_req = 1; m_gnt = 1;
    lkp_addr = 64'hA0; rfl_addr = 64'hB0;
    for (int i = 0; i < MO; i++) begin
      #1;
`ifdef MPT_PLB_ARB_RR_EN
      exp_id = (i % 2 == 0);
`else
      exp_id = 1'b1;
`endif
      checks++;
      if (rfl_gnt !== exp_id || lkp_gnt !== !exp_id) begin
        errors++;
        $display("FAIL fill_grant%0d: rg=%0b lg=%0b want rg=%0b",
                 i, rfl_gnt, lkp_gnt, exp_id);
      end
      q.push_back(exp_id);
      @(negedge clk);
    end
    #1;
    checks++;
    if (m_req !== 0 || outstanding !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: req=%0b outst=%0d want 0 4", m_req, outstanding);
    end
    @(negedge clk);
    lkp_req = 0; rfl_req = 0; m_gnt = 0; m_valid = 1;
    for (int i = 0; i < MO; i++) begin
      #1;
      checks++;
      if (rfl_valid !== q[i] || lkp_valid !== !q[i]) begin
        errors++;
        $display("FAIL fill_drain%0d: rv=%0b lv=%0b want rv=%0b",
                 i, rfl_valid, lkp_valid, q[i]);
      end
      @(negedge clk);
    end
    m_valid = 0;
    #1;
    checks++;
    if (outstanding !== 3'd0 || perr !== 0) begin
      errors++;
      $display("FAIL fill_empty: outst=%0d perr=%0b want 0 0",
               outstanding, perr);
    end
    @(negedge clk);
  endtask

  task automatic test_lock();
    do_reset();
    lkp_req = 1; lkp_addr = 64'h2000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (m_req !== 1 || m_addr !== 64'h2000 || lkp_gnt !== 0) begin
        errors++;
        $display("FAIL lock_wait%0d: req=%0b addr=%h lg=%0b want 1 2000 0",
                 i, m_req, m_addr, lkp_gnt);
      end
      @(negedge clk);
    end
    rfl_req = 1; rfl_addr = 64'h3000;
    #1;
    checks++;
    if (m_addr !== 64'h2000) begin
      errors++;
      $display("FAIL lock_hold: addr=%h want 2000", m_addr);
    end
    @(negedge clk);
    m_gnt = 1;
    #1;
    checks++;
    if (lkp_gnt !== 1 || rfl_gnt !== 0) begin
      errors++;
      $display("FAIL lock_first: lg=%0b rg=%0b want 1 0", lkp_gnt, rfl_gnt);
    end
    @(negedge clk);
    lkp_req = 0;
    #1;
    checks++;
    if (rfl_gnt !== 1 || m_addr !== 64'h3000) begin
      errors++;
      $display("FAIL lock_second: rg=%0b addr=%h want 1 3000", rfl_gnt, m_addr);
    end
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic test_error_route();
    do_reset();
    lkp_req = 1; m_gnt = 1;
    #1;
    @(negedge clk);
    lkp_req = 0; rfl_req = 1;
    #1;
    checks++;
    if (rfl_gnt !== 1 || outstanding !== 3'd1) begin
      errors++;
      $display("FAIL err_grants: rg=%0b outst=%0d want 1 1", rfl_gnt, outstanding);
    end
    @(negedge clk);
    rfl_req = 0; m_gnt = 0; m_valid = 1; m_error = 0; m_rdata = 1;
    #1;
    checks++;
    if (lkp_valid !== 1 || lkp_error !== 0 || lkp_rdata !== 1'b1 ||
        rfl_valid !== 0 || rfl_rdata !== 0) begin
      errors++;
      $display("FAIL err_first: lv=%0b le=%0b rv=%0b want 1 0 0",
               lkp_valid, lkp_error, rfl_valid);
    end
    @(negedge clk);
    m_error = 1; m_rdata = 0;
    #1;
    checks++;
    if (rfl_valid !== 1 || rfl_error !== 1 || lkp_valid !== 0 ||
        lkp_error !== 0) begin
      errors++;
      $display("FAIL err_second: rv=%0b re=%0b lv=%0b le=%0b want 1 1 0 0",
               rfl_valid, rfl_error, lkp_valid, lkp_error);
    end
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    lkp_req = 1; m_gnt = 1;
    @(negedge clk);
    lkp_req = 0; rfl_req = 1;
    @(negedge clk);
    rfl_req = 0;
    flush = 1; lkp_req = 1; lkp_addr = 64'h4000; m_valid = 1;
    #1;
    checks++;
    if (m_req !== 0 || lkp_gnt !== 0 || lkp_valid !== 1 || outstanding !== 3'd2)
    begin
      errors++;
      $display("FAIL flush_first: req=%0b lg=%0b lv=%0b outst=%0d want 0 0 1 2",
               m_req, lkp_gnt, lkp_valid, outstanding);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_req !== 0 || rfl_valid !== 1 || lkp_valid !== 0) begin
      errors++;
      $display("FAIL flush_second: req=%0b rv=%0b lv=%0b want 0 1 0",
               m_req, rfl_valid, lkp_valid);
    end
    @(negedge clk);
    m_valid = 0;
    #1;
    checks++;
    if (outstanding !== 3'd0 || m_req !== 0) begin
      errors++;
      $display("FAIL flush_idle: outst=%0d req=%0b want 0 0", outstanding, m_req);
    end
    @(negedge clk);
    flush = 0;
    #1;
    checks++;
    if (m_req !== 1 || lkp_gnt !== 1 || m_addr !== 64'h4000) begin
      errors++;
      $display("FAIL flush_release: req=%0b lg=%0b addr=%h want 1 1 4000",
               m_req, lkp_gnt, m_addr);
    end
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic test_protocol_error();
    do_reset();
    m_valid = 1; m_rdata = 1; m_error = 1;
    #1;
    checks++;
    if (lkp_valid !== 0 || rfl_valid !== 0 || lkp_rdata !== 0 ||
        rfl_error !== 0) begin
      errors++;
      $display("FAIL perr_drop: lv=%0b rv=%0b want 0 0", lkp_valid, rfl_valid);
    end
    @(negedge clk);
    m_valid = 0;
    #1;
    checks++;
    if (perr !== 1 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL perr_set: perr=%0b outst=%0d want 1 0", perr, outstanding);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (perr !== 1) begin
      errors++;
      $display("FAIL perr_sticky: perr=%0b want 1", perr);
    end
    do_reset();
    #1;
    checks++;
    if (perr !== 0) begin
      errors++;
      $display("FAIL perr_clear: perr=%0b want 0", perr);
    end
  endtask

  // Model: a queue of requester IDs, per-slave pending requests that stay
  // up until granted, and a held selection while the master stalls.
  task automatic test_random();
    bit q[$];
    bit pend_l, pend_r, held, held_id, last_id;
    bit sel, sel_req, exp_req, exp_lv, exp_rv;
    logic [AW-1:0] al, ar;
    logic [BW-1:0] bl, br;
    logic [DW-1:0] dl, dr;
    bit wl, wr;
    do_reset();
    pend_l = 0; pend_r = 0; held = 0; held_id = 0; last_id = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend_l && ($urandom % 3 == 0)) begin
        pend_l = 1; al = {$urandom, $urandom};
        bl = BW'($urandom); dl = DW'($urandom); wl = 1'($urandom);
      end
      if (!pend_r && ($urandom % 3 == 0)) begin
        pend_r = 1; ar = {$urandom, $urandom};
        br = BW'($urandom); dr = DW'($urandom); wr = 1'($urandom);
      end
      lkp_req = pend_l; lkp_addr = al; lkp_be = bl;
      lkp_wdata = dl; lkp_we = wl;
      rfl_req = pend_r; rfl_addr = ar; rfl_be = br;
      rfl_wdata = dr; rfl_we = wr;
      flush = ($urandom % 8 == 0);
      m_gnt = 1'($urandom);
      m_valid = (q.size() > 0) && ($urandom % 2 == 0);
      m_rdata = DW'($urandom);
      m_error = 1'($urandom);
      if (held) sel = held_id;
      else if (pend_l && pend_r)
`ifdef MPT_PLB_ARB_RR_EN
        sel = !last_id;
`else
        sel = 1;
`endif
      else sel = pend_r;
      sel_req = sel ? pend_r : pend_l;
      exp_req = sel_req && (q.size() < MO) && (held || !flush);
      exp_lv = m_valid && (q.size() > 0) && (q[0] == 0);
      exp_rv = m_valid && (q.size() > 0) && (q[0] == 1);
      #1;
      checks++;
      if (m_req !== exp_req || lkp_gnt !== (exp_req && m_gnt && !sel) ||
          rfl_gnt !== (exp_req && m_gnt && sel)) begin
        errors++;
        $display("FAIL rnd_arb c%0d: req=%0b lg=%0b rg=%0b want req=%0b sel=%0b",
                 c, m_req, lkp_gnt, rfl_gnt, exp_req, sel);
      end
      if (exp_req) begin
        checks++;
        if (m_addr !== (sel ? ar : al) || m_be !== (sel ? br : bl) ||
            m_wdata !== (sel ? dr : dl) || m_we !== (sel ? wr : wl)) begin
          errors++;
          $display("FAIL rnd_mux c%0d: addr=%h want %h", c, m_addr,
                   sel ? ar : al);
        end
      end
      checks++;
      if (lkp_valid !== exp_lv || rfl_valid !== exp_rv ||
          lkp_rdata !== (exp_lv ? m_rdata : '0) ||
          rfl_rdata !== (exp_rv ? m_rdata : '0) ||
          lkp_error !== (exp_lv && m_error) ||
          rfl_error !== (exp_rv && m_error)) begin
        errors++;
        $display("FAIL rnd_resp c%0d: lv=%0b rv=%0b want %0b %0b",
                 c, lkp_valid, rfl_valid, exp_lv, exp_rv);
      end
      checks++;
      if (int'(outstanding) != q.size() || perr !== 0) begin
        errors++;
        $display("FAIL rnd_count c%0d: outst=%0d perr=%0b want %0d 0",
                 c, outstanding, perr, q.size());
      end
      @(posedge clk);
      if (m_valid) void'(q.pop_front());
      if (exp_req && m_gnt) begin
        q.push_back(sel);
        if (sel) pend_r = 0; else pend_l = 0;
        held = 0;
        last_id = sel;
      end else if (exp_req) begin
        held = 1;
        held_id = sel;
      end
      @(negedge clk);
    end
    zero_inputs();
  endtask

  initial begin
    rst_n = 0;
    zero_inputs();
    test_reset();
    test_lookup_single();
    test_fill_full();
    test_lock();
    test_error_route();
    test_flush();
    test_protocol_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
